// File: rtl/ex_muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit_if
// Handshake/operand bundle between the ID/EX pipeline register (master) and
// the RV32M multiply/divide unit (slave).
//   START   master->slave  M-extension op valid in ID/EX this cycle
//   FLUSH   master->slave  abort any in-flight op
//   FUNCT3  master->slave  operation select (MUL..REMU)
//   DATA1   master->slave  rs1 operand
//   DATA2   master->slave  rs2 operand
//   RESULT  slave->master  registered result, held until next completion
//   BUSY    slave->master  stall request to the pipeline registers
//   DONE    slave->master  one-cycle result-valid pulse
// ----------------------------------------------------------------------------
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
) ();
    logic            START;
    logic            FLUSH;
    logic [2:0]      FUNCT3;
    logic [XLEN-1:0] DATA1;
    logic [XLEN-1:0] DATA2;
    logic [XLEN-1:0] RESULT;
    logic            BUSY;
    logic            DONE;

    modport master (
        output START, FLUSH, FUNCT3, DATA1, DATA2,
        input  RESULT, BUSY, DONE
    );

    modport slave (
        input  START, FLUSH, FUNCT3, DATA1, DATA2,
        output RESULT, BUSY, DONE
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
// Multi-cycle RV32M multiply/divide unit sitting behind the ID/EX register.
// Radix-2 iterative datapath: 32 iterations followed by one sign-fixup cycle.
// Divide-by-zero and signed overflow complete via a one-cycle fast path.
//   CLK    clock, all state updates on posedge
//   RESET  synchronous, active-low reset
//   bus    ex_muldiv_unit_if.slave (START/FLUSH/FUNCT3/DATA1/DATA2 in,
//          RESULT/BUSY/DONE out)
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    ex_muldiv_unit_if.slave     bus
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   hi_q;      // product high half / partial remainder
    logic [XLEN-1:0]   lo_q;      // multiplier -> product low / dividend -> quotient
    logic [XLEN-1:0]   opb_q;     // multiplicand / divisor magnitude
    logic [XLEN-1:0]   result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic              done_q;

    // ---------------------------------------------------------------- decode
    logic              in_rs1_signed;
    logic              in_rs2_signed;
    logic              in_sign1;
    logic              in_sign2;
    logic              in_is_div;
    logic              in_is_rem;
    logic              in_neg;
    logic              in_div0;
    logic              in_ovf;
    logic [XLEN-1:0]   in_mag1;
    logic [XLEN-1:0]   in_mag2;
    logic [XLEN-1:0]   in_special_res;

    always_comb begin
        in_rs1_signed = 1'b0;
        in_rs2_signed = 1'b0;
        case (bus.FUNCT3)
            3'b001:  begin in_rs1_signed = 1'b1; in_rs2_signed = 1'b1; end // MULH
            3'b010:  begin in_rs1_signed = 1'b1; in_rs2_signed = 1'b0; end // MULHSU
            3'b100:  begin in_rs1_signed = 1'b1; in_rs2_signed = 1'b1; end // DIV
            3'b110:  begin in_rs1_signed = 1'b1; in_rs2_signed = 1'b1; end // REM
            default: begin in_rs1_signed = 1'b0; in_rs2_signed = 1'b0; end
        endcase

        in_is_div = bus.FUNCT3[2];
        in_is_rem = bus.FUNCT3[2] & bus.FUNCT3[1];
        in_sign1  = in_rs1_signed & bus.DATA1[XLEN-1];
        in_sign2  = in_rs2_signed & bus.DATA2[XLEN-1];
        in_mag1   = in_sign1 ? (~bus.DATA1 + 1'b1) : bus.DATA1;
        in_mag2   = in_sign2 ? (~bus.DATA2 + 1'b1) : bus.DATA2;
        // Remainder takes the dividend's sign; everything else sign1^sign2.
        in_neg    = in_is_rem ? in_sign1 : (in_sign1 ^ in_sign2);

        in_div0   = in_is_div & (bus.DATA2 == '0);
        in_ovf    = in_is_div & ~bus.FUNCT3[0]
                  & (bus.DATA1 == {1'b1, {(XLEN-1){1'b0}}})
                  & (bus.DATA2 == '1);

        if (in_div0)
            in_special_res = in_is_rem ? bus.DATA1 : '1;
        else
            in_special_res = in_is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // ------------------------------------------------------------- iteration
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   hi_d;
    logic [XLEN-1:0]   lo_d;

    always_comb begin
        // Multiply: add multiplicand into the high half when the current
        // multiplier bit is set, then shift the 65-bit {carry,hi,lo} right.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        // Restoring divide: partial remainder shifted left by one dividend bit.
        // The subtraction only needs XLEN bits because it is only kept when
        // the shifted value is >= divisor, leaving a result below the divisor.
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift[XLEN-1:0] - opb_q;

        if (op_q[2]) begin
            if (div_shift >= {1'b0, opb_q}) begin
                hi_d = div_diff;
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = div_shift[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // ---------------------------------------------------------------- fixup
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        // The product is negated as a full 64-bit value so MULH* sees the
        // borrow from the low half; quotient and remainder negate separately.
        prod_fix = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
        quo_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
        rem_fix  = neg_q ? (~hi_q + 1'b1) : hi_q;
        case (op_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.FLUSH) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.START) begin
                        op_q  <= bus.FUNCT3;
                        cnt_q <= '0;
                        hi_q  <= '0;
                        lo_q  <= in_mag1;
                        opb_q <= in_mag2;
                        neg_q <= in_neg;
                        if (in_div0 || in_ovf) begin
                            result_q <= in_special_res;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1))
                        state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q <= fix_res;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    // The stalled instruction is still in ID/EX, so START is
                    // ignored here to avoid re-issuing it.
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY   = ((state_q == S_IDLE) & bus.START & ~bus.FLUSH)
                      | (state_q == S_CALC)
                      | (state_q == S_FIX);
    assign bus.DONE   = done_q;
    assign bus.RESULT = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Directed testbench for ex_muldiv_unit: latency, results, special cases,
// flush/reset abort and back-to-back issue.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    ex_muldiv_unit_if #(.XLEN(32)) bus ();

    ex_muldiv_unit #(.XLEN(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks;
    int failures;

    // Issues one op in cycle 0 and observes it; comparisons are done by the
    // calling test. Operands are scrambled after cycle 0.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int done_cyc,
                         output int busy_cnt, output int busy_last,
                         output logic done_after);
        @(negedge CLK);
        bus.START  = 1'b1;
        bus.FUNCT3 = f3;
        bus.DATA1  = a;
        bus.DATA2  = b;
        done_cyc   = -1;
        busy_cnt   = 0;
        busy_last  = -1;
        res        = '0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (bus.BUSY === 1'b1) begin
                busy_cnt++;
                busy_last = c;
            end
            if (bus.DONE === 1'b1) begin
                done_cyc = c;
                res      = bus.RESULT;
                break;
            end
            @(negedge CLK);
            bus.START = 1'b0;
            bus.DATA1 = ~a;
            bus.DATA2 = b ^ 32'h5A5A_5A5A;
        end
        bus.START = 1'b0;
        @(negedge CLK);
        #1 done_after = bus.DONE;
        bus.DATA1 = '0;
        bus.DATA2 = '0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        int dc, bc, bl;
        logic da;
        logic bad;
        do_op(3'b000, 32'd7, 32'd3, r, dc, bc, bl, da);
        checks++;
        if (r !== 32'd21) begin
            failures++;
            $display("FAIL reset_pre_mul: got %h expected %h", r, 32'd21);
        end
        // Start an op, then hold reset for two edges mid-flight.
        @(negedge CLK);
        bus.START = 1'b1; bus.FUNCT3 = 3'b100; bus.DATA1 = 32'd99; bus.DATA2 = 32'd4;
        repeat (4) @(negedge CLK);
        bus.START = 1'b0;
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if (bus.RESULT !== 32'd0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got result=%h busy=%b done=%b expected 0/0/0",
                     bus.RESULT, bus.BUSY, bus.DONE);
        end
        RESET = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            #1;
            if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got activity=%b expected 0", bad);
        end
    endtask

    // Runs a table of ops expected to finish in cycle exp_done with BUSY in
    // cycles 0..exp_done-1.
    task automatic run_table(input string tag, input logic [2:0] f[4],
                             input logic [31:0] a[4], input logic [31:0] b[4],
                             input logic [31:0] e[4], input int exp_done);
        logic [31:0] r;
        int dc, bc, bl;
        logic da;
        for (int i = 0; i < 4; i++) begin
            do_op(f[i], a[i], b[i], r, dc, bc, bl, da);
            checks++;
            if (r !== e[i]) begin
                failures++;
                $display("FAIL %s_result[%0d]: got %h expected %h", tag, i, r, e[i]);
            end
            checks++;
            if (dc !== exp_done) begin
                failures++;
                $display("FAIL %s_done_cycle[%0d]: got %0d expected %0d", tag, i, dc, exp_done);
            end
            checks++;
            if (bc !== exp_done || bl !== exp_done - 1) begin
                failures++;
                $display("FAIL %s_busy[%0d]: got count=%0d last=%0d expected count=%0d last=%0d",
                         tag, i, bc, bl, exp_done, exp_done - 1);
            end
            checks++;
            if (da !== 1'b0) begin
                failures++;
                $display("FAIL %s_done_pulse[%0d]: got %b expected 0", tag, i, da);
            end
        end
    endtask

    task automatic test_mul();
        logic [2:0]  f[4];
        logic [31:0] a[4], b[4], e[4];
        f = '{3'b000, 3'b001, 3'b011, 3'b010};
        a = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        b = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2};
        e = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        run_table("mul", f, a, b, e, 34);
    endtask

    task automatic test_div();
        logic [2:0]  f[4];
        logic [31:0] a[4], b[4], e[4];
        f = '{3'b100, 3'b110, 3'b101, 3'b111};
        a = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20};
        b = '{32'd3, 32'd3, 32'd3, 32'd3};
        e = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd6, 32'd2};
        run_table("div", f, a, b, e, 34);
    endtask

    task automatic test_special();
        logic [2:0]  f[4];
        logic [31:0] a[4], b[4], e[4];
        f = '{3'b100, 3'b111, 3'b100, 3'b110};
        a = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        b = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        e = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        run_table("special", f, a, b, e, 1);
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int dc, bc, bl;
        logic da;
        logic seen;
        do_op(3'b101, 32'd20, 32'd3, r, dc, bc, bl, da);
        checks++;
        if (r !== 32'd6) begin
            failures++;
            $display("FAIL flush_pre_result: got %h expected %h", r, 32'd6);
        end
        @(negedge CLK);
        bus.START = 1'b1; bus.FUNCT3 = 3'b100; bus.DATA1 = 32'd100; bus.DATA2 = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            bus.START = 1'b0;
        end
        bus.FLUSH = 1'b1;
        #1;
        checks++;
        if (bus.BUSY !== 1'b1) begin
            failures++;
            $display("FAIL flush_busy_c10: got %b expected 1", bus.BUSY);
        end
        @(negedge CLK);
        bus.FLUSH = 1'b0;
        #1;
        checks++;
        if (bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy_c11: got %b expected 0", bus.BUSY);
        end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            #1;
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus.RESULT !== 32'd6) begin
            failures++;
            $display("FAIL flush_no_done: got activity=%b result=%h expected 0/%h",
                     seen, bus.RESULT, 32'd6);
        end
        // FLUSH together with START in IDLE: nothing starts.
        @(negedge CLK);
        bus.START = 1'b1; bus.FLUSH = 1'b1; bus.FUNCT3 = 3'b101;
        bus.DATA1 = 32'd9; bus.DATA2 = 32'd2;
        #1;
        checks++;
        if (bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL flush_start_busy: got %b expected 0", bus.BUSY);
        end
        @(negedge CLK);
        bus.START = 1'b0; bus.FLUSH = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            #1;
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus.RESULT !== 32'd6) begin
            failures++;
            $display("FAIL flush_start_no_op: got activity=%b result=%h expected 0/%h",
                     seen, bus.RESULT, 32'd6);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge CLK);
        bus.START = 1'b1; bus.FUNCT3 = 3'b100; bus.DATA1 = 32'd100; bus.DATA2 = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            bus.START = 1'b0;
        end
        RESET = 1'b0;
        @(negedge CLK);
        #1;
        checks++;
        if (bus.RESULT !== 32'd0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: got result=%h busy=%b done=%b expected 0/0/0",
                     bus.RESULT, bus.BUSY, bus.DONE);
        end
        RESET = 1'b1;
    endtask

    task automatic test_back_to_back();
        int          d1c, d2c, nd;
        logic [31:0] d1r, d2r;
        logic        b34, b35;
        d1c = -1; d2c = -1; nd = 0; d1r = '0; d2r = '0; b34 = 1'bx; b35 = 1'bx;
        for (int c = 0; c < 80; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                bus.START = 1'b1; bus.FUNCT3 = 3'b101; bus.DATA1 = 32'd20; bus.DATA2 = 32'd3;
            end else if (c == 34) begin
                bus.START = 1'b1; bus.FUNCT3 = 3'b000;
                bus.DATA1 = 32'h1234_5678; bus.DATA2 = 32'h10;
            end else if (c == 1 || c == 36) begin
                bus.START = 1'b0;
            end
            #1;
            if (c == 34) b34 = bus.BUSY;
            if (c == 35) b35 = bus.BUSY;
            if (bus.DONE === 1'b1) begin
                if (nd == 0) begin d1c = c; d1r = bus.RESULT; end
                else if (nd == 1) begin d2c = c; d2r = bus.RESULT; end
                nd++;
            end
        end
        bus.START = 1'b0;
        checks++;
        if (d1c !== 34 || d1r !== 32'd6) begin
            failures++;
            $display("FAIL b2b_first: got cycle=%0d result=%h expected 34/%h", d1c, d1r, 32'd6);
        end
        checks++;
        if (b34 !== 1'b0 || b35 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy: got c34=%b c35=%b expected 0/1", b34, b35);
        end
        checks++;
        if (d2c !== 69 || d2r !== 32'h2345_6780) begin
            failures++;
            $display("FAIL b2b_second: got cycle=%0d result=%h expected 69/%h",
                     d2c, d2r, 32'h2345_6780);
        end
        checks++;
        if (nd !== 2) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d expected 2", nd);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        RESET      = 1'b0;
        bus.START  = 1'b0;
        bus.FLUSH  = 1'b0;
        bus.FUNCT3 = 3'b000;
        bus.DATA1  = '0;
        bus.DATA2  = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_reset_abort();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
